// File: rtl/xalu_md_if.sv
// Issue/result bundle between the E-stage control and the multiply/divide unit.
// The control side drives the operation; the unit returns Busy, HI/LO and the mfhi/mflo value.
interface xalu_md_if;
    logic        Start;
    logic [3:0]  XALUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] Out;

    modport master (output Start, XALUOp, A, B, input Busy, HI, LO, Out);
    modport slave  (input Start, XALUOp, A, B, output Busy, HI, LO, Out);
endinterface

// File: rtl/xalu_md.sv
// Multi-cycle multiply/divide unit with HI/LO registers and fixed result latency.
// Define XALU_MADD_EN to accept madd/maddu/msub/msubu (ops 9-12) with multiply latency.
module xalu_md #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic      clk,
    input logic      reset,
    xalu_md_if.slave bus
);
    localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    typedef enum logic {IDLE, RUN} state_e;

    state_e          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            is_mul, is_div, issue;
    logic            load, commit, wr_hi, wr_lo;
    logic [31:0]     hi, lo;
    logic [31:0]     a_p0, b_p0;
    logic [3:0]      op_p0;
    logic signed [31:0] sa_p0, sb_p0;
    logic signed [63:0] prod_s;
    logic [63:0]     prod_u;
    logic [63:0]     res;
    logic            div_by_zero;
`ifdef XALU_MADD_EN
    logic [63:0]     hilo_p0;
`endif

    always_comb begin
        is_mul = (bus.XALUOp == OP_MULT) || (bus.XALUOp == OP_MULTU);
`ifdef XALU_MADD_EN
        is_mul = is_mul || (bus.XALUOp >= OP_MADD && bus.XALUOp <= OP_MSUBU);
`endif
        is_div = (bus.XALUOp == OP_DIV) || (bus.XALUOp == OP_DIVU);
    end

    assign issue    = bus.Start && (is_mul || is_div);
    assign bus.Busy = issue || (cnt != '0);
    assign bus.HI   = hi;
    assign bus.LO   = lo;
    assign bus.Out  = (bus.XALUOp == OP_MFHI) ? hi :
                      (bus.XALUOp == OP_MFLO) ? lo : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Start is only honoured in IDLE; the stall logic keeps it away during RUN.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        commit    = 1'b0;
        wr_hi     = 1'b0;
        wr_lo     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Start) begin
                    if (is_mul) begin
                        load      = 1'b1;
                        cnt_nxt   = CW'(MULT_CYCLES);
                        state_nxt = RUN;
                    end else if (is_div) begin
                        load      = 1'b1;
                        cnt_nxt   = CW'(DIV_CYCLES);
                        state_nxt = RUN;
                    end else if (bus.XALUOp == OP_MTHI) begin
                        wr_hi = 1'b1;
                    end else if (bus.XALUOp == OP_MTLO) begin
                        wr_lo = 1'b1;
                    end
                end
            end
            RUN: begin
                cnt_nxt = cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture at issue (stage p0)
    always_ff @(posedge clk) begin
        if (load) begin
            a_p0  <= bus.A;
            b_p0  <= bus.B;
            op_p0 <= bus.XALUOp;
`ifdef XALU_MADD_EN
            hilo_p0 <= {hi, lo};
`endif
        end
    end

    assign sa_p0  = $signed(a_p0);
    assign sb_p0  = $signed(b_p0);
    assign prod_s = $signed({{32{a_p0[31]}}, a_p0}) * $signed({{32{b_p0[31]}}, b_p0});
    assign prod_u = {32'd0, a_p0} * {32'd0, b_p0};
    assign div_by_zero = ((op_p0 == OP_DIV) || (op_p0 == OP_DIVU)) && (b_p0 == 32'd0);

    always_comb begin
        res = {hi, lo};
        case (op_p0)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_DIV:   res = {sa_p0 % sb_p0, sa_p0 / sb_p0};
            OP_DIVU:  res = {a_p0 % b_p0, a_p0 / b_p0};
`ifdef XALU_MADD_EN
            OP_MADD:  res = hilo_p0 + prod_s;
            OP_MADDU: res = hilo_p0 + prod_u;
            OP_MSUB:  res = hilo_p0 - prod_s;
            OP_MSUBU: res = hilo_p0 - prod_u;
`endif
            default:  res = {hi, lo};
        endcase
    end

    // HI/LO commit on the cnt 1->0 edge; divide by zero leaves them untouched
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            if (!div_by_zero) begin
                hi <= res[63:32];
                lo <= res[31:0];
            end
        end else begin
            if (wr_hi) hi <= bus.A;
            if (wr_lo) lo <= bus.A;
        end
    end
endmodule
